// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the multi-cycle ALU and its bench.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_n_subtractor.sv
// Ripple-style adder/subtractor: c=1 computes a-b via two's complement, cout is the carry out.
module adder_n_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {WIDTH{c}}} + {{WIDTH{1'b0}}, c};

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIVU/REMU
// sharing one accumulator, one shift register and one counter; valid/ready on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sub_en;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   trial;
    logic             multi;
    logic [SHW-1:0]   shamt;

    assign sub_en = (alucontrol != OP_ADD);
    assign shamt  = b[SHW-1:0];
    assign multi  = (alucontrol == OP_MUL) || (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);

    adder_n_subtractor #(.WIDTH(WIDTH)) u_addsub (
        .a    (a),
        .b    (b),
        .c    (sub_en),
        .s    (sum),
        .cout (cout)
    );

    // Signed less-than: differing signs decide directly, otherwise the difference sign does.
    assign slt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];

    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OP_ADD, OP_SUB: alu_res = sum;
            OP_AND:         alu_res = a & b;
            OP_OR:          alu_res = a | b;
            OP_XOR:         alu_res = a ^ b;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, ~cout};
            OP_SLL:         alu_res = a << shamt;
            OP_SRL:         alu_res = a >> shamt;
            OP_SRA:         alu_res = $signed(a) >>> shamt;
            default:        alu_res = '0;
        endcase
    end

    // Partial remainder stays below the divisor, so bit WIDTH of the trial flags a negative result.
    assign trial = {acc_q, sh_q[WIDTH-1]} - {1'b0, opd_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opd_d    = opd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = alucontrol;
                    if (multi) begin
                        acc_d   = '0;
                        sh_d    = (alucontrol == OP_MUL) ? b : a;
                        opd_d   = (alucontrol == OP_MUL) ? a : b;
                        cnt_d   = '0;
                        state_d = S_ITER;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_ITER: begin
                if (op_q == OP_MUL) begin
                    acc_d = {acc_q[WIDTH-2:0], 1'b0} + (sh_q[WIDTH-1] ? opd_q : '0);
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end else if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = (op_q == OP_DIVU) ? sh_d : acc_d;
                    zero_d   = (result_d == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opd_q    <= opd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ITER);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 alucontrol  input  4  opcode, encodings per alu_pkg.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, high when result is all zeros.
REQ-014 busy  output  1  high while an iterative operation runs.

Function
REQ-015 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR (codes 0-3 match the legacy 3-bit ALU), 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL, 1011 DIVU, 1100 REMU; 1101-1111 give result 0 and zero 1.
REQ-016 FSM states IDLE, ITER, DONE; in_ready = (state==IDLE); busy = (state==ITER).
REQ-017 Handshake: accept on the edge where in_valid && in_ready; a, b and alucontrol are captured then; later input changes are ignored.
REQ-018 Single-cycle ops: IDLE->DONE on acceptance; out_valid high from the first edge after acceptance.
REQ-019 MUL, DIVU, REMU: IDLE->ITER on acceptance; exactly WIDTH iteration cycles; ITER->DONE on the WIDTH-th; out_valid high WIDTH+1 edges after acceptance.
REQ-020 DONE holds result, zero and out_valid stable until out_ready is sampled high; DONE->IDLE on that edge; out_valid drops with it.
REQ-021 No acceptance in DONE, even if out_ready is high in the same cycle; back-to-back throughput is one op per 2 cycles minimum.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
REQ-023 SLT is a signed compare and SLTU an unsigned compare; result is 1 or 0, zero-extended to WIDTH.
REQ-024 Shifts use b[SHW-1:0] only; SRA replicates a[WIDTH-1].
REQ-025 MUL returns the low WIDTH bits of unsigned a*b via shift-add, one bit per cycle.
REQ-026 DIVU/REMU use restoring division, one quotient bit per cycle; unsigned.
REQ-027 For b==0, DIVU returns all-ones and REMU returns a; still WIDTH cycles; no exception.
REQ-028 zero is computed from the final result value and is valid whenever out_valid is high.

Reset
REQ-029 While reset is asserted: state=IDLE, out_valid=0, busy=0, result=0, zero=1, iteration counter=0; in_ready=1 after release.
REQ-030 Reset during ITER or DONE aborts the operation; the pending result is discarded and no out_valid follows.

Structure
REQ-031 Package alu_pkg holds the 4-bit opcode localparams and the FSM state encoding; the module imports it.
REQ-032 ADD, SUB, SLT and SLTU reuse the existing adder_n_subtractor sub-module; SUB/compare drive its c input high.
REQ-033 One shared WIDTH-bit accumulator, one operand shift register and one $clog2(WIDTH)+1-bit counter serve both MUL and DIV.

Verification
REQ-034 Reset release, then ADD a=0x7FFFFFFF, b=1 -> out_valid on the next edge, result 0x80000000, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-035 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0; SRA a=0x80000000, b=0x24 -> 0xF8000000 (shift 4).
REQ-036 MUL a=0x10001, b=0x10001 -> busy for 32 cycles, out_valid 33 edges after acceptance, result 0x00020001.
REQ-037 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-038 Hold out_ready low 5 cycles after out_valid -> result stable, in_ready 0, in_valid ignored; raise out_ready -> IDLE next edge.
REQ-039 Assert reset at iteration 10 of a DIVU -> IDLE immediately, out_valid never rises, next ADD completes correctly.
